// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port (icache/dcache) memory arbiter.
// The optional burst lock is enabled by defining MEM_ARB_BURST_LOCK_EN.
package mem_arb_pkg;

  localparam int   MEM_W    = 32;
  localparam logic P_ICACHE = 1'b0;
  localparam logic P_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side signals of the arbiter, grouped as one bundle.
// slave = arbiter view, master = surrounding system / bench view.
interface mem_arb_if import mem_arb_pkg::*; ();

  logic [MEM_W-1:0] i_p0_mem_addr;
  logic             i_p0_mem_ren;
  logic             i_p0_mem_wen;
  logic [MEM_W-1:0] i_p0_mem_wdata;
  logic             o_p0_mem_ready;
  logic             o_p0_mem_valid;
  logic [MEM_W-1:0] o_p0_mem_rdata;

  logic [MEM_W-1:0] i_p1_mem_addr;
  logic             i_p1_mem_ren;
  logic             i_p1_mem_wen;
  logic [MEM_W-1:0] i_p1_mem_wdata;
  logic             o_p1_mem_ready;
  logic             o_p1_mem_valid;
  logic [MEM_W-1:0] o_p1_mem_rdata;

  logic [MEM_W-1:0] o_mem_addr;
  logic             o_mem_ren;
  logic             o_mem_wen;
  logic [MEM_W-1:0] o_mem_wdata;
  logic             i_mem_ready;
  logic             i_mem_valid;
  logic [MEM_W-1:0] i_mem_rdata;

  logic [1:0]       o_grant;

  modport slave (
    input  i_p0_mem_addr, i_p0_mem_ren, i_p0_mem_wen, i_p0_mem_wdata,
    output o_p0_mem_ready, o_p0_mem_valid, o_p0_mem_rdata,
    input  i_p1_mem_addr, i_p1_mem_ren, i_p1_mem_wen, i_p1_mem_wdata,
    output o_p1_mem_ready, o_p1_mem_valid, o_p1_mem_rdata,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    input  i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_grant
  );

  modport master (
    output i_p0_mem_addr, i_p0_mem_ren, i_p0_mem_wen, i_p0_mem_wdata,
    input  o_p0_mem_ready, o_p0_mem_valid, o_p0_mem_rdata,
    output i_p1_mem_addr, i_p1_mem_ren, i_p1_mem_wen, i_p1_mem_wdata,
    input  o_p1_mem_ready, o_p1_mem_valid, o_p1_mem_rdata,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata,
    output i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_grant
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port rr names.
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) grant = rr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache (port 0) and dcache (port 1) onto one memory port, one beat per grant.
// Define MEM_ARB_BURST_LOCK_EN to keep a granted port for BURST_BEATS beats.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int BURST_BEATS = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mem_arb_if.slave  bus
);

  state_t           state_reg;
  logic             rr_reg;
  logic             idx_reg;
  logic [1:0]       grant_reg;

  logic [1:0]       req_vec;
  logic [1:0]       arb_req;
  logic [1:0]       arb_grant;
  logic             arb_rr;

  logic [MEM_W-1:0] sel_addr;
  logic [MEM_W-1:0] sel_wdata;
  logic             sel_ren;
  logic             sel_wen;
  logic             busy;
  logic             resp;
  logic             fwd_valid;
  logic             beat_done;

  assign req_vec = {bus.i_p1_mem_ren | bus.i_p1_mem_wen,
                    bus.i_p0_mem_ren | bus.i_p0_mem_wen};

`ifdef MEM_ARB_BURST_LOCK_EN
  localparam int LOCK_W = $clog2(BURST_BEATS + 1);

  logic [LOCK_W-1:0] lock_cnt_reg;
  logic              locked;
  logic              lock_hold;

  // While locked only the owner may be granted; if it goes quiet the lock drops
  // and the other port gets priority on the same cycle.
  assign locked    = (lock_cnt_reg != '0);
  assign lock_hold = locked && req_vec[idx_reg];
  assign arb_req   = lock_hold ? port_onehot(idx_reg) : req_vec;
  assign arb_rr    = locked ? ~idx_reg : rr_reg;
`else
  assign arb_req   = req_vec;
  assign arb_rr    = rr_reg;
`endif

  mem_arb_rr u_rr (
    .req   (arb_req),
    .rr    (arb_rr),
    .grant (arb_grant)
  );

  always_comb begin
    if (idx_reg == P_DCACHE) begin
      sel_addr  = bus.i_p1_mem_addr;
      sel_wdata = bus.i_p1_mem_wdata;
      sel_ren   = bus.i_p1_mem_ren;
      sel_wen   = bus.i_p1_mem_wen;
    end else begin
      sel_addr  = bus.i_p0_mem_addr;
      sel_wdata = bus.i_p0_mem_wdata;
      sel_ren   = bus.i_p0_mem_ren;
      sel_wen   = bus.i_p0_mem_wen;
    end
  end

  // Outputs are gated by reset so nothing leaks in the cycle reset is first seen.
  assign busy      = (state_reg == BUSY) && !i_rst;
  assign resp      = (state_reg == RESP) && !i_rst;
  assign fwd_valid = bus.i_mem_valid && (resp || (busy && !sel_wen && bus.i_mem_ready));
  assign beat_done = ((state_reg == BUSY) && bus.i_mem_ready && (sel_wen || bus.i_mem_valid))
                  || ((state_reg == RESP) && bus.i_mem_valid);

  assign bus.o_mem_addr     = busy ? sel_addr  : '0;
  assign bus.o_mem_wdata    = busy ? sel_wdata : '0;
  assign bus.o_mem_wen      = busy && sel_wen;
  assign bus.o_mem_ren      = busy && sel_ren && !sel_wen;

  assign bus.o_p0_mem_ready = busy && (idx_reg == P_ICACHE) && bus.i_mem_ready;
  assign bus.o_p1_mem_ready = busy && (idx_reg == P_DCACHE) && bus.i_mem_ready;
  assign bus.o_p0_mem_valid = fwd_valid && (idx_reg == P_ICACHE);
  assign bus.o_p1_mem_valid = fwd_valid && (idx_reg == P_DCACHE);
  assign bus.o_p0_mem_rdata = bus.i_mem_rdata;
  assign bus.o_p1_mem_rdata = bus.i_mem_rdata;
  assign bus.o_grant        = grant_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      rr_reg       <= P_ICACHE;
      idx_reg      <= P_ICACHE;
      grant_reg    <= '0;
`ifdef MEM_ARB_BURST_LOCK_EN
      lock_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (|arb_grant) begin
            state_reg <= BUSY;
            grant_reg <= arb_grant;
            idx_reg   <= arb_grant[1];
          end
        end
        BUSY: begin
          if (bus.i_mem_ready) state_reg <= (sel_wen || bus.i_mem_valid) ? IDLE : RESP;
        end
        RESP: begin
          if (bus.i_mem_valid) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (beat_done) begin
        grant_reg <= '0;
`ifdef MEM_ARB_BURST_LOCK_EN
        if (lock_cnt_reg != '0) lock_cnt_reg <= lock_cnt_reg - 1'b1;
        if (lock_cnt_reg <= LOCK_W'(1)) rr_reg <= ~idx_reg;
`else
        rr_reg <= ~idx_reg;
`endif
      end

`ifdef MEM_ARB_BURST_LOCK_EN
      if (state_reg == IDLE) begin
        if (locked && !lock_hold) begin
          lock_cnt_reg <= '0;
          rr_reg       <= ~idx_reg;
        end
        if ((|arb_grant) && !lock_hold) lock_cnt_reg <= LOCK_W'(BURST_BEATS);
      end
`endif
    end
  end

endmodule
